plic_gateway_array: RTL and testbench
=====================================

# plic_gateway_array

Parametrised array of PLIC interrupt gateways: one gateway channel per interrupt source, each converting a level or edge source into a single pending request for the PLIC core. Adds per-source trigger mode and polarity, a saturating pending-edge counter with sticky overflow, and ID-addressed claim/complete. Sits between the raw synchronous interrupt lines and the PLIC priority/target arbitration logic.

## Interface
- `SRC_NUM`, 32: number of interrupt sources (1..1023).
- `CNT_WIDTH`, 4: width of each pending-edge counter and of `tnm_i`.
- `ID_WIDTH`, `$clog2(SRC_NUM+1)`: claim/complete ID width; source `i` has ID `i+1`; ID 0 is reserved.

- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `irq_i`  in  SRC_NUM  raw interrupt lines, already synchronous to `clk_i`.
- `tm_i`  in  SRC_NUM  trigger mode per source: `PLIC_TM_LEVL` or `PLIC_TM_EDGE`.
- `pol_i`  in  SRC_NUM  polarity per source: 0 = active-high/rising, 1 = active-low/falling.
- `tnm_i`  in  CNT_WIDTH  max pending edges per source, shared; 0 is treated as 1.
- `clam_i`  in  1  claim strobe, single cycle.
- `clam_id_i`  in  ID_WIDTH  source ID being claimed.
- `comp_i`  in  1  complete strobe, single cycle.
- `comp_id_i`  in  ID_WIDTH  source ID being completed.
- `ovf_clr_i`  in  SRC_NUM  per-source clear of the overflow flag.
- `ip_o`  out  SRC_NUM  interrupt pending to PLIC core.
- `busy_o`  out  SRC_NUM  source claimed, awaiting completion.
- `ovf_o`  out  SRC_NUM  sticky overflow: an edge was dropped at saturation.

## Operation
- Effective input `e = irq_i[i] ^ pol_i[i]`; previous sample `e_q` registered per source.
- Edge event: `e & ~e_q` (edge mode only).
- Per-channel FSM, 2-bit: IDLE (00), PEND (01), SERV (10); `ip_o = state==PEND`, `busy_o = state==SERV`.
- IDLE→PEND: level mode and `e`==1; or edge mode and `cnt_q != 0`.
- PEND→SERV: `clam_i` and `clam_id_i == i+1`. Level input deasserting while PEND does not clear PEND.
- SERV→IDLE: `comp_i` and `comp_id_i == i+1`.
- Claim to a source not in PEND, complete to a source not in SERV, ID 0, or ID > SRC_NUM: ignored, no state change.
- Counter (edge mode): +1 on edge event, −1 on accepted claim; both in same cycle → unchanged. Never underflows.
- Saturation: edge event with `cnt_q >= max(tnm_i,1)` and no claim → count unchanged, `ovf_o[i]` set.
- `ovf_clr_i[i]` clears `ovf_o[i]`; simultaneous set and clear → set wins.
- Level mode: counter forced to 0 every cycle; edge events ignored; `ovf_o` not set.
- `tnm_i` lowered below a current count: count held, decremented only by claims; further edges overflow.
- Mode change while PEND or SERV: FSM continues unaffected; counter rules of new mode apply from that cycle.

## Timing
- Reset: FSMs IDLE, counters 0, `e_q` 0, `ovf_o` 0; thus `ip_o`, `busy_o`, `ovf_o` all 0.
- Reset with `e` already high in edge mode: counts as an edge on the first clock after reset release.
- Edge latency: `e` rises before edge k → `cnt_q`=1 after edge k → `ip_o` high after edge k+1.
- Level latency: `e` high at edge k → `ip_o` high after edge k.
- Claim accepted at edge k → `ip_o` low, `busy_o` high after edge k.
- Complete at edge k → IDLE after k; if condition still true, `ip_o` high again after k+1 (one idle cycle minimum).
- Claim and complete to same ID in same cycle: only the transition valid for the current state applies.

## Structure
- `plic_define.sv`: `PLIC_TM_LEVL`, `PLIC_TM_EDGE`, and FSM state encodings GW_IDLE/GW_PEND/GW_SERV.
- Sub-module `plic_gateway_chan`: one source (FSM, counter, edge detect, overflow); receives decoded one-hot `clam_hit`/`comp_hit`.
- Top: ID decode to one-hot claim/complete vectors, generate loop of `SRC_NUM` channels; state regs via `dffr`.

## Test plan
- Reset, SRC_NUM=4, all irq low → all outputs 0; edge mode src 2 pulse → `ip_o`=4'b0100 two cycles after rise.
- Edge src 0, tnm_i=3, 5 pulses, no claim → cnt 3, `ovf_o[0]`=1; three claim/complete pairs (ID 1) → three `ip_o` assertions, then idle; `ovf_clr_i[0]` → `ovf_o[0]`=0.
- Level src 1, pol_i=1, irq_i[1] driven low → `ip_o[1]` after 1 cycle; claim ID 2 → `busy_o[1]`; complete with irq still low → `ip_o[1]` re-asserts one cycle later.
- Edge event and claim same cycle on src 3 with cnt 1 → cnt stays 1, `busy_o[3]`=1, `ip_o[3]` again after complete.
- Claim ID 0, ID 5, and ID of IDLE source; complete of PEND source → no state change anywhere.
- Assert `rst_n_i` mid-SERV with cnt 2 → all outputs 0 immediately, counters 0.

Source files
------------

// File: rtl/plic_gateway_array_pkg.sv
// plic_gateway_array_pkg
// Shared definitions for the PLIC gateway array: trigger-mode encodings and
// the per-channel gateway FSM state encoding.
package plic_gateway_array_pkg;

    // Trigger mode, one bit per source on tm_i.
    localparam logic PLIC_TM_LEVL = 1'b0;
    localparam logic PLIC_TM_EDGE = 1'b1;

    typedef enum logic [1:0] {
        GW_IDLE = 2'b00,
        GW_PEND = 2'b01,
        GW_SERV = 2'b10
    } gw_state_e;

endpackage

// File: rtl/plic_gateway_chan.sv
// plic_gateway_chan
// One PLIC gateway channel: edge detect, pending-edge counter with sticky
// overflow, and the IDLE/PEND/SERV request FSM.
// Ports:
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   irq_i, tm_i, pol_i   raw source, trigger mode, polarity
//   tnm_i                max pending edges (0 behaves as 1)
//   clam_hit_i           claim addressed to this channel
//   comp_hit_i           complete addressed to this channel
//   ovf_clr_i            clear sticky overflow
//   ip_o, busy_o, ovf_o  pending, claimed, overflow
module plic_gateway_chan
    import plic_gateway_array_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 irq_i,
    input  logic                 tm_i,
    input  logic                 pol_i,
    input  logic [CNT_WIDTH-1:0] tnm_i,
    input  logic                 clam_hit_i,
    input  logic                 comp_hit_i,
    input  logic                 ovf_clr_i,
    output logic                 ip_o,
    output logic                 busy_o,
    output logic                 ovf_o
);

    gw_state_e             state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  e_q;
    logic                  ovf_q, ovf_d;

    logic                  e;
    logic                  edge_ev;
    logic                  clam_acc;
    logic [CNT_WIDTH-1:0]  tnm_eff;

    assign e        = irq_i ^ pol_i;
    assign edge_ev  = (tm_i == PLIC_TM_EDGE) && e && !e_q;
    assign clam_acc = clam_hit_i && (state_q == GW_PEND);
    assign tnm_eff  = (tnm_i == '0) ? CNT_WIDTH'(1) : tnm_i;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (tm_i == PLIC_TM_LEVL) begin
            cnt_d = '0;
        end else if (edge_ev && clam_acc) begin
            // Incoming edge replaces the one being claimed.
            cnt_d = cnt_q;
        end else if (edge_ev) begin
            if (cnt_q >= tnm_eff) begin
                ovf_d = 1'b1;  // set wins over a simultaneous clear
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end else if (clam_acc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GW_IDLE: begin
                if ((tm_i == PLIC_TM_LEVL) ? e : (cnt_q != '0)) begin
                    state_d = GW_PEND;
                end
            end
            GW_PEND: begin
                if (clam_hit_i) begin
                    state_d = GW_SERV;
                end
            end
            GW_SERV: begin
                if (comp_hit_i) begin
                    state_d = GW_IDLE;
                end
            end
            default: state_d = GW_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= GW_IDLE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            e_q     <= e;
            ovf_q   <= ovf_d;
        end
    end

    assign ip_o   = (state_q == GW_PEND);
    assign busy_o = (state_q == GW_SERV);
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/plic_gateway_array.sv
// plic_gateway_array
// Array of PLIC interrupt gateways, one channel per source. Decodes the
// claim/complete IDs (source i has ID i+1, ID 0 reserved) into one-hot hit
// vectors and instantiates SRC_NUM gateway channels.
// Ports:
//   clk_i, rst_n_i                    clock, asynchronous active-low reset
//   irq_i, tm_i, pol_i                per-source line, trigger mode, polarity
//   tnm_i                             shared max pending edges
//   clam_i/clam_id_i, comp_i/comp_id_i claim and complete strobes with ID
//   ovf_clr_i                         per-source overflow clear
//   ip_o, busy_o, ovf_o               per-source pending, claimed, overflow
module plic_gateway_array
    import plic_gateway_array_pkg::*;
#(
    parameter int unsigned SRC_NUM   = 32,
    parameter int unsigned CNT_WIDTH = 4,
    parameter int unsigned ID_WIDTH  = $clog2(SRC_NUM + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [SRC_NUM-1:0]   irq_i,
    input  logic [SRC_NUM-1:0]   tm_i,
    input  logic [SRC_NUM-1:0]   pol_i,
    input  logic [CNT_WIDTH-1:0] tnm_i,
    input  logic                 clam_i,
    input  logic [ID_WIDTH-1:0]  clam_id_i,
    input  logic                 comp_i,
    input  logic [ID_WIDTH-1:0]  comp_id_i,
    input  logic [SRC_NUM-1:0]   ovf_clr_i,
    output logic [SRC_NUM-1:0]   ip_o,
    output logic [SRC_NUM-1:0]   busy_o,
    output logic [SRC_NUM-1:0]   ovf_o
);

    logic [SRC_NUM-1:0] clam_hit;
    logic [SRC_NUM-1:0] comp_hit;

    for (genvar i = 0; i < SRC_NUM; i++) begin : g_chan
        // ID 0 and IDs above SRC_NUM never match any channel.
        assign clam_hit[i] = clam_i && (clam_id_i == ID_WIDTH'(i + 1));
        assign comp_hit[i] = comp_i && (comp_id_i == ID_WIDTH'(i + 1));

        plic_gateway_chan #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_chan (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .irq_i      (irq_i[i]),
            .tm_i       (tm_i[i]),
            .pol_i      (pol_i[i]),
            .tnm_i      (tnm_i),
            .clam_hit_i (clam_hit[i]),
            .comp_hit_i (comp_hit[i]),
            .ovf_clr_i  (ovf_clr_i[i]),
            .ip_o       (ip_o[i]),
            .busy_o     (busy_o[i]),
            .ovf_o      (ovf_o[i])
        );
    end

endmodule

// File: tb/tb_plic_gateway_array.sv
// tb_plic_gateway_array
// Directed-vector bench for plic_gateway_array with SRC_NUM=4.
module tb_plic_gateway_array;
    import plic_gateway_array_pkg::*;

    localparam int unsigned SrcNum   = 4;
    localparam int unsigned CntWidth = 4;
    localparam int unsigned IdWidth  = 3;

    logic                clk_i = 1'b0;
    logic                rst_n_i;
    logic [SrcNum-1:0]   irq_i;
    logic [SrcNum-1:0]   tm_i;
    logic [SrcNum-1:0]   pol_i;
    logic [CntWidth-1:0] tnm_i;
    logic                clam_i;
    logic [IdWidth-1:0]  clam_id_i;
    logic                comp_i;
    logic [IdWidth-1:0]  comp_id_i;
    logic [SrcNum-1:0]   ovf_clr_i;
    logic [SrcNum-1:0]   ip_o;
    logic [SrcNum-1:0]   busy_o;
    logic [SrcNum-1:0]   ovf_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk_i = ~clk_i;

    plic_gateway_array #(
        .SRC_NUM   (SrcNum),
        .CNT_WIDTH (CntWidth),
        .ID_WIDTH  (IdWidth)
    ) u_dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .irq_i     (irq_i),
        .tm_i      (tm_i),
        .pol_i     (pol_i),
        .tnm_i     (tnm_i),
        .clam_i    (clam_i),
        .clam_id_i (clam_id_i),
        .comp_i    (comp_i),
        .comp_id_i (comp_id_i),
        .ovf_clr_i (ovf_clr_i),
        .ip_o      (ip_o),
        .busy_o    (busy_o),
        .ovf_o     (ovf_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse(input int s);
        irq_i[s] = 1'b1;
        tick();
        irq_i[s] = 1'b0;
        tick();
    endtask

    task automatic claim(input int id);
        clam_i    = 1'b1;
        clam_id_i = IdWidth'(id);
        tick();
        clam_i    = 1'b0;
        clam_id_i = '0;
    endtask

    task automatic complete(input int id);
        comp_i    = 1'b1;
        comp_id_i = IdWidth'(id);
        tick();
        comp_i    = 1'b0;
        comp_id_i = '0;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: bench exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n_i   = 1'b0;
        irq_i     = '0;
        tm_i      = '0;
        pol_i     = '0;
        tnm_i     = 4'd3;
        clam_i    = 1'b0;
        clam_id_i = '0;
        comp_i    = 1'b0;
        comp_id_i = '0;
        ovf_clr_i = '0;
        tick();
        tick();
        check_eq("rst_ip", 32'(ip_o), 32'h0);
        check_eq("rst_busy", 32'(busy_o), 32'h0);
        check_eq("rst_ovf", 32'(ovf_o), 32'h0);
        rst_n_i = 1'b1;
        // Sources 0, 2, 3 edge; source 1 level.
        tm_i = {PLIC_TM_EDGE, PLIC_TM_EDGE, PLIC_TM_LEVL, PLIC_TM_EDGE};
        tick();

        // Edge on src 2: pending two edges after the rise.
        irq_i[2] = 1'b1;
        tick();
        check_eq("e2_lat1", 32'(ip_o), 32'h0);
        tick();
        check_eq("e2_lat2", 32'(ip_o), 32'h4);
        irq_i[2] = 1'b0;
        claim(3);
        check_eq("e2_clm_busy", 32'(busy_o), 32'h4);
        check_eq("e2_clm_ip", 32'(ip_o), 32'h0);
        complete(3);
        check_eq("e2_cmp_busy", 32'(busy_o), 32'h0);
        tick();
        check_eq("e2_idle", 32'(ip_o), 32'h0);

        // Src 0: five edges with tnm=3 saturate at 3 and overflow.
        for (int k = 0; k < 5; k++) pulse(0);
        check_eq("sat_ip", 32'(ip_o), 32'h1);
        check_eq("sat_ovf", 32'(ovf_o), 32'h1);
        for (int k = 0; k < 3; k++) begin
            claim(1);
            check_eq("sat_busy", 32'(busy_o), 32'h1);
            complete(1);
            check_eq("sat_cmp_ip", 32'(ip_o), 32'h0);
            tick();
            check_eq("sat_reip", 32'(ip_o), (k < 2) ? 32'h1 : 32'h0);
        end
        check_eq("sat_busy_end", 32'(busy_o), 32'h0);
        check_eq("ovf_sticky", 32'(ovf_o), 32'h1);
        ovf_clr_i[0] = 1'b1;
        tick();
        ovf_clr_i[0] = 1'b0;
        check_eq("ovf_clr", 32'(ovf_o), 32'h0);

        // Src 1 level, active-low.
        pol_i[1] = 1'b1;
        irq_i[1] = 1'b1;
        tick();
        check_eq("lvl_quiet", 32'(ip_o), 32'h0);
        irq_i[1] = 1'b0;
        tick();
        check_eq("lvl_lat", 32'(ip_o), 32'h2);
        claim(2);
        check_eq("lvl_busy", 32'(busy_o), 32'h2);
        check_eq("lvl_clm_ip", 32'(ip_o), 32'h0);
        complete(2);
        check_eq("lvl_cmp_ip", 32'(ip_o), 32'h0);
        tick();
        check_eq("lvl_reip", 32'(ip_o), 32'h2);
        irq_i[1] = 1'b1;
        tick();
        check_eq("lvl_hold", 32'(ip_o), 32'h2);
        claim(2);
        complete(2);
        tick();
        check_eq("lvl_idle", 32'(ip_o | busy_o), 32'h0);

        // Src 3: edge and claim in the same cycle keep the count at 1.
        pulse(3);
        check_eq("ec_pend", 32'(ip_o), 32'h8);
        irq_i[3] = 1'b1;
        claim(4);
        irq_i[3] = 1'b0;
        check_eq("ec_busy", 32'(busy_o), 32'h8);
        complete(4);
        check_eq("ec_cmp_ip", 32'(ip_o), 32'h0);
        tick();
        check_eq("ec_reip", 32'(ip_o), 32'h8);
        claim(4);
        complete(4);
        tick();
        check_eq("ec_idle", 32'(ip_o), 32'h0);

        // Ignored claims/completes while src 0 is pending.
        pulse(0);
        check_eq("ign_pend", 32'(ip_o), 32'h1);
        claim(0);
        check_eq("ign_id0", 32'({busy_o, ip_o}), 32'h01);
        claim(5);
        check_eq("ign_id5", 32'({busy_o, ip_o}), 32'h01);
        claim(7);
        check_eq("ign_id7", 32'({busy_o, ip_o}), 32'h01);
        claim(2);
        check_eq("ign_idle", 32'({busy_o, ip_o}), 32'h01);
        complete(1);
        check_eq("ign_cmp", 32'({busy_o, ip_o}), 32'h01);

        // Reset mid-SERV with count 2 (count 3 then one claim).
        pulse(0);
        pulse(0);
        claim(1);
        check_eq("rs_busy", 32'(busy_o), 32'h1);
        rst_n_i = 1'b0;
        #1;
        check_eq("rs_async", 32'({ovf_o, busy_o, ip_o}), 32'h0);
        tick();
        rst_n_i = 1'b1;
        tick();
        tick();
        tick();
        check_eq("rs_cnt0", 32'({ovf_o, busy_o, ip_o}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
